// File: rtl/hex_button_pkg.sv
// Shared constants for the HPS hex-display / push-button controller:
// register offsets, CTRL bit positions and the 7-segment glyph table.
package hex_button_pkg;

    localparam int NUM_DIGITS = 6;
    localparam int NUM_KEYS   = 4;

    localparam logic [2:0] ADDR_CTRL    = 3'd0;
    localparam logic [2:0] ADDR_DIGITS  = 3'd1;
    localparam logic [2:0] ADDR_COUNTER = 3'd2;
    localparam logic [2:0] ADDR_BTN     = 3'd3;
    localparam logic [2:0] ADDR_EDGE    = 3'd4;

    localparam int CTRL_MODE     = 0;
    localparam int CTRL_BLINK    = 1;
    localparam int CTRL_IRQ_EN   = 2;
    localparam int CTRL_MASK_LSB = 8;

    localparam logic [31:0] CTRL_RESET = 32'h0000_3F00;
    localparam logic [31:0] CTRL_WMASK = 32'h0000_3F07;

    localparam int KEY_INC   = 0;
    localparam int KEY_DEC   = 1;
    localparam int KEY_CLR   = 2;
    localparam int KEY_BLINK = 3;

    // Active-high segments, bit6=g .. bit0=a; pins take the complement.
    function automatic logic [6:0] seg7(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'h3F;
            4'h1: s = 7'h06;
            4'h2: s = 7'h5B;
            4'h3: s = 7'h4F;
            4'h4: s = 7'h66;
            4'h5: s = 7'h6D;
            4'h6: s = 7'h7D;
            4'h7: s = 7'h07;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h6F;
            4'hA: s = 7'h77;
            4'hB: s = 7'h7C;
            4'hC: s = 7'h39;
            4'hD: s = 7'h5E;
            4'hE: s = 7'h79;
            default: s = 7'h71;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/hex_button_ctrl_if.sv
// Avalon-MM slave bus plus interrupt line between the lightweight HPS bridge
// and the hex/button controller.
interface hex_button_ctrl_if;
    logic [2:0]  address;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        irq;

    modport master (output address, read, write, writedata, input readdata, irq);
    modport slave  (input address, read, write, writedata, output readdata, irq);
endinterface

// File: rtl/button_debounce.sv
// One push-button: two-flop synchroniser, terminal-count debounce timer,
// accepted level and a single-cycle press pulse on the accepted 0->1 step.
module button_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic reset,
    input  logic raw_n,
    output logic level,
    output logic press
);
    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync_meta;
    logic          sync_q;
    logic [CW-1:0] cnt_q;

    // Timer reloads whenever the synchronised input agrees with the accepted
    // level, so any bounce back restarts the full debounce window.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_meta <= 1'b0;
            sync_q    <= 1'b0;
            cnt_q     <= CNT_LOAD;
            level     <= 1'b0;
            press     <= 1'b0;
        end else begin
            sync_meta <= ~raw_n;
            sync_q    <= sync_meta;
            press     <= 1'b0;
            if (sync_q == level) begin
                cnt_q <= CNT_LOAD;
            end else if (cnt_q == '0) begin
                level <= sync_q;
                press <= sync_q;
                cnt_q <= CNT_LOAD;
            end else begin
                cnt_q <= cnt_q - 1'b1;
            end
        end
    end

endmodule

// File: rtl/hex_button_ctrl.sv
// Register file, local button counter, display source mux, segment decode
// with masking/blink, and the blink prescaler for the six hex displays.
module hex_button_ctrl
    import hex_button_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int BLINK_CYCLES    = 25000000
) (
    input  logic               clk,
    input  logic               reset,
    hex_button_ctrl_if.slave   avs,
    input  logic [3:0]         buttons_n,
    output logic [6:0]         hex0,
    output logic [6:0]         hex1,
    output logic [6:0]         hex2,
    output logic [6:0]         hex3,
    output logic [6:0]         hex4,
    output logic [6:0]         hex5
);
    localparam int PW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
    localparam logic [PW-1:0] PRESCALE_LOAD = PW'(BLINK_CYCLES - 1);

    logic [NUM_KEYS-1:0] btn_level;
    logic [NUM_KEYS-1:0] btn_press;

    logic [31:0] ctrl_q;
    logic [23:0] digits_q;
    logic [23:0] counter_q;
    logic [23:0] counter_d;
    logic [3:0]  edge_q;
    logic        irq_q;
    logic [31:0] readdata_q;
    logic [31:0] rd_mux;
    logic [PW-1:0] prescale_q;
    logic        phase_q;
    logic [23:0] src;
    logic        blank_all;
    logic [6:0]  hex_d [NUM_DIGITS];
    logic [6:0]  hex_q [NUM_DIGITS];

    logic wr_ctrl;
    logic wr_digits;
    logic wr_counter;
    logic wr_edge;

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
        button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debounce (
            .clk   (clk),
            .reset (reset),
            .raw_n (buttons_n[i]),
            .level (btn_level[i]),
            .press (btn_press[i])
        );
    end

    assign wr_ctrl    = avs.write && (avs.address == ADDR_CTRL);
    assign wr_digits  = avs.write && (avs.address == ADDR_DIGITS);
    assign wr_counter = avs.write && (avs.address == ADDR_COUNTER);
    assign wr_edge    = avs.write && (avs.address == ADDR_EDGE);

    // A bus write of CTRL overrides a same-cycle KEY3 blink toggle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ctrl_q <= CTRL_RESET;
        end else if (wr_ctrl) begin
            ctrl_q <= avs.writedata & CTRL_WMASK;
        end else if (btn_press[KEY_BLINK]) begin
            ctrl_q[CTRL_BLINK] <= ~ctrl_q[CTRL_BLINK];
        end
    end

    always_comb begin
        counter_d = counter_q;
        if (wr_counter) begin
            counter_d = avs.writedata[23:0];
        end else if (btn_press[KEY_CLR]) begin
            counter_d = '0;
        end else if (btn_press[KEY_INC]) begin
            counter_d = counter_q + 24'd1;
        end else if (btn_press[KEY_DEC]) begin
            counter_d = counter_q - 24'd1;
        end
    end

    // Press capture is OR-ed in after the W1C clear so a new press is never lost.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            digits_q  <= '0;
            counter_q <= '0;
            edge_q    <= '0;
            irq_q     <= 1'b0;
        end else begin
            if (wr_digits) begin
                digits_q <= avs.writedata[23:0];
            end
            counter_q <= counter_d;
            edge_q    <= (edge_q & ~(wr_edge ? avs.writedata[3:0] : 4'h0)) | btn_press;
            irq_q     <= ctrl_q[CTRL_IRQ_EN] & (|edge_q);
        end
    end

    always_comb begin
        rd_mux = '0;
        case (avs.address)
            ADDR_CTRL:    rd_mux = ctrl_q;
            ADDR_DIGITS:  rd_mux = {8'h0, digits_q};
            ADDR_COUNTER: rd_mux = {8'h0, counter_q};
            ADDR_BTN:     rd_mux = {28'h0, btn_level};
            ADDR_EDGE:    rd_mux = {28'h0, edge_q};
            default:      rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            readdata_q <= '0;
        end else if (avs.read) begin
            readdata_q <= rd_mux;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prescale_q <= PRESCALE_LOAD;
            phase_q    <= 1'b0;
        end else if (prescale_q == '0) begin
            prescale_q <= PRESCALE_LOAD;
            phase_q    <= ~phase_q;
        end else begin
            prescale_q <= prescale_q - 1'b1;
        end
    end

    always_comb begin
        src       = ctrl_q[CTRL_MODE] ? counter_q : digits_q;
        blank_all = ctrl_q[CTRL_BLINK] & phase_q;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            hex_d[k] = (blank_all || !ctrl_q[CTRL_MASK_LSB + k]) ? 7'h7F : ~seg7(src[4*k +: 4]);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < NUM_DIGITS; k++) begin
                hex_q[k] <= 7'h7F;
            end
        end else begin
            for (int k = 0; k < NUM_DIGITS; k++) begin
                hex_q[k] <= hex_d[k];
            end
        end
    end

    assign avs.readdata = readdata_q;
    assign avs.irq      = irq_q;
    assign hex0 = hex_q[0];
    assign hex1 = hex_q[1];
    assign hex2 = hex_q[2];
    assign hex3 = hex_q[3];
    assign hex4 = hex_q[4];
    assign hex5 = hex_q[5];

endmodule
